// File: rtl/bus_ram_target.sv
// Word-organised RAM target on the shared system bus with programmable wait states and byte-masked writes.
// Latency: fc_bus pulses 1+WAIT_CYCLES cycles after the request edge; data_bus/fc_bus are high-Z unless responding.
// Optional: define BUS_RAM_TARGET_WP_EN to add the wp input (write protect, writes complete but do not commit).
module bus_ram_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    input  logic        wr_bus,
    input  logic        rd_bus,
    input  logic [3:0]  data_mask_bus,
    output wire         fc_bus
`ifdef BUS_RAM_TARGET_WP_EN
    ,
    input  logic        wp
`endif
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;
    logic                enter_ack;

    logic [ADDR_W-1:0]   cap_idx;
    logic                cap_rd;
    logic                cap_wr;
    logic [3:0]          cap_mask;
    logic [31:0]         cap_data;
    logic [31:0]         rd_data;

    logic [31:0]         mem [DEPTH];

    logic                sel;
    logic                req_ok;
    logic [ADDR_W-1:0]   acc_idx;
    logic                acc_rd;
    logic                acc_wr;
    logic [3:0]          acc_mask;
    logic [31:0]         acc_data;
    logic                wp_block;
    logic                do_write;
    logic                do_read;

    wire                 unused_addr_lsb = &{1'b0, addr_bus[1:0]};

`ifdef BUS_RAM_TARGET_WP_EN
    assign wp_block = wp;
`else
    assign wp_block = 1'b0;
`endif

    assign sel    = (addr_bus[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign req_ok = sel & (rd_bus ^ wr_bus);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        enter_ack = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // A withdrawn request aborts; the address lines are not re-checked here.
                if (!rd_bus && !wr_bus) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if ((!rd_bus && !wr_bus) || !sel) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // With no wait states the ACK entry edge is the capture edge, so use the live bus then.
    assign acc_idx  = (state == ST_IDLE) ? addr_bus[ADDR_W+1:2] : cap_idx;
    assign acc_rd   = (state == ST_IDLE) ? rd_bus               : cap_rd;
    assign acc_wr   = (state == ST_IDLE) ? wr_bus               : cap_wr;
    assign acc_mask = (state == ST_IDLE) ? data_mask_bus        : cap_mask;
    assign acc_data = (state == ST_IDLE) ? data_bus             : cap_data;

    assign do_write = enter_ack & acc_wr & ~wp_block & ~rst;
    assign do_read  = enter_ack & acc_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            cap_idx  <= '0;
            cap_rd   <= 1'b0;
            cap_wr   <= 1'b0;
            cap_mask <= 4'd0;
            cap_data <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && req_ok) begin
                cap_idx  <= addr_bus[ADDR_W+1:2];
                cap_rd   <= rd_bus;
                cap_wr   <= wr_bus;
                cap_mask <= data_mask_bus;
                cap_data <= data_bus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 32'd0;
        end else if (do_read) begin
            rd_data <= mem[acc_idx];
        end
    end

    assign data_bus = (state == ST_ACK && cap_rd) ? rd_data : 32'bz;
    assign fc_bus   = (state == ST_WAIT) ? 1'b0 :
                      (state == ST_ACK)  ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_ram_target.sv
// Directed bench for bus_ram_target (WAIT_CYCLES=1): table of bus transactions plus hand-built corner sequences.
// Define BUS_RAM_TARGET_WP_EN to also exercise the write-protect input.
module tb_bus_ram_target;

    localparam int WAITS = 1;
    localparam int LAT   = 1 + WAITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_bus = 32'd0;
    logic        wr_bus = 1'b0;
    logic        rd_bus = 1'b0;
    logic [3:0]  data_mask_bus = 4'd0;
    logic        drv_en = 1'b0;
    logic [31:0] drv_dat = 32'd0;
    wire  [31:0] data_bus;
    wire         fc_bus;
`ifdef BUS_RAM_TARGET_WP_EN
    logic        wp = 1'b0;
`endif

    assign data_bus = drv_en ? drv_dat : 32'bz;

    wire fc_z  = (fc_bus === 1'bz);
    wire dat_z = (data_bus === 32'bz);

    always #5 clk = ~clk;

    bus_ram_target #(
        .BASE_ADDR  (32'h0001_0000),
        .ADDR_W     (10),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_bus     (addr_bus),
        .data_bus     (data_bus),
        .wr_bus       (wr_bus),
        .rd_bus       (rd_bus),
        .data_mask_bus(data_mask_bus),
        .fc_bus       (fc_bus)
`ifdef BUS_RAM_TARGET_WP_EN
        ,
        .wp           (wp)
`endif
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_idle(input string name, input bit want_dat_z);
        n_checks++;
        if (!fc_z || (want_dat_z && !dat_z)) begin
            n_err++;
            $display("FAIL %s: fc_hiz=%0d dat_hiz=%0d, expected both high-Z", name, fc_z, dat_z);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask);
        addr_bus      = addr;
        wr_bus        = is_wr;
        rd_bus        = !is_wr;
        data_mask_bus = mask;
        drv_dat       = data;
        drv_en        = is_wr;
    endtask

    task automatic stop();
        wr_bus = 1'b0;
        rd_bus = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic wait_fc(output int lat, output logic [31:0] d);
        lat = -1;
        d   = 32'd0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (fc_bus === 1'b1) begin
                lat = n;
                d   = data_bus;
                break;
            end
        end
    endtask

    task automatic do_txn(input string name, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask, input logic [31:0] exp);
        int          lat;
        logic [31:0] d;
        start(is_wr, addr, data, mask);
        wait_fc(lat, d);
        chk({name, " latency"}, 32'(lat), 32'(LAT));
        if (!is_wr) chk({name, " rdata"}, d, exp);
        stop();
        tick();
        chk_idle({name, " release"}, 1'b1);
        tick();
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] d;

        vecs[0]  = '{1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0001_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0001_0010, 32'h1122_3344, 4'h5, 32'h0};
        vecs[3]  = '{1'b0, 32'h0001_0010, 32'h0,         4'hF, 32'hDE22_BE44};
        vecs[4]  = '{1'b1, 32'h0001_0013, 32'hA5A5_A5A5, 4'h8, 32'h0};
        vecs[5]  = '{1'b0, 32'h0001_0010, 32'h0,         4'h0, 32'hA522_BE44};
        vecs[6]  = '{1'b1, 32'h0001_0FFC, 32'h1234_5678, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 32'h0001_0FFC, 32'h0,         4'hF, 32'h1234_5678};
        vecs[8]  = '{1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 32'h0001_0000, 32'h0,         4'hF, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 32'h0001_0010, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 32'h0001_0012, 32'h0,         4'hF, 32'hA522_BE44};
        vecs[12] = '{1'b1, 32'h0001_0024, 32'h9999_9999, 4'hF, 32'h0};
        vecs[13] = '{1'b0, 32'h0001_0024, 32'h0,         4'hF, 32'h9999_9999};

        // Reset and idle bus
        tick();
        chk_idle("reset outputs", 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle($sformatf("idle bus c%0d", i), 1'b1);
        end

        for (int i = 0; i < 14; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].is_wr, vecs[i].addr, vecs[i].data,
                   vecs[i].mask, vecs[i].exp);
        end

        // Out-of-window write (aliases word 0 if decode were broken) and read
        start(1'b1, 32'h0002_0000, 32'h0000_0000, 4'hF);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("oow wr c%0d", i), 1'b0);
        end
        stop();
        start(1'b0, 32'h0002_0000, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("oow rd c%0d", i), 1'b1);
        end
        stop();
        tick();
        do_txn("oow untouched", 1'b0, 32'h0001_0000, 32'h0, 4'hF, 32'hCAFE_F00D);

        // Read held long after fc: a single pulse only
        start(1'b0, 32'h0001_0010, 32'h0, 4'hF);
        wait_fc(lat, d);
        chk("held rd latency", 32'(lat), 32'(LAT));
        chk("held rd data", d, 32'hA522_BE44);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) chk_idle("held rd after fc", 1'b1);
            if (fc_bus === 1'b1) pulses++;
        end
        chk("held rd extra pulses", 32'(pulses), 32'd0);
        stop();
        tick();
        tick();

        // rd and wr together: protocol error, no response
        start(1'b1, 32'h0001_0010, 32'h0, 4'hF);
        rd_bus = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!fc_z) pulses++;
        end
        chk("rd+wr fc activity", 32'(pulses), 32'd0);
        stop();
        tick();
        do_txn("rd+wr no write", 1'b0, 32'h0001_0010, 32'h0, 4'hF, 32'hA522_BE44);

        // Write withdrawn during WAIT
        start(1'b1, 32'h0001_0010, 32'h0, 4'hF);
        tick();
        n_checks++;
        if (fc_z || fc_bus !== 1'b0) begin
            n_err++;
            $display("FAIL wait fc drive: hiz=%0d val=%b, expected driven 0", fc_z, fc_bus);
        end
        stop();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fc_bus === 1'b1) pulses++;
        end
        chk("withdraw pulses", 32'(pulses), 32'd0);
        do_txn("withdraw no write", 1'b0, 32'h0001_0010, 32'h0, 4'hF, 32'hA522_BE44);

        // Address changed during WAIT: captured word 8 is written, word 9 keeps its value
        start(1'b1, 32'h0001_0020, 32'h8888_8888, 4'hF);
        tick();
        addr_bus = 32'h0001_0024;
        drv_dat  = 32'h0;
        wait_fc(lat, d);
        chk("addr change latency", 32'(lat + 1), 32'(LAT));
        stop();
        tick();
        tick();
        do_txn("addr change w8", 1'b0, 32'h0001_0020, 32'h0, 4'hF, 32'h8888_8888);
        do_txn("addr change w9", 1'b0, 32'h0001_0024, 32'h0, 4'hF, 32'h9999_9999);

        // Reset during WAIT of a write to word 4
        start(1'b1, 32'h0001_0010, 32'h0, 4'hF);
        tick();
        rst = 1'b1;
        stop();
        #1;
        chk_idle("rst mid-wait", 1'b1);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fc_bus === 1'b1) pulses++;
        end
        chk("rst pulses", 32'(pulses), 32'd0);
        do_txn("rst lost write", 1'b0, 32'h0001_0010, 32'h0, 4'hF, 32'hA522_BE44);

`ifdef BUS_RAM_TARGET_WP_EN
        wp = 1'b1;
        do_txn("wp write", 1'b1, 32'h0001_0000, 32'h0, 4'hF, 32'h0);
        do_txn("wp read", 1'b0, 32'h0001_0000, 32'h0, 4'hF, 32'hCAFE_F00D);
        wp = 1'b0;
        do_txn("wp off write", 1'b1, 32'h0001_0000, 32'h0BAD_CAFE, 4'hF, 32'h0);
        do_txn("wp off read", 1'b0, 32'h0001_0000, 32'h0, 4'hF, 32'h0BAD_CAFE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bus_ram_target.md
Name: bus_ram_target

Overview:
Word-organised RAM that responds on the shared system bus (addr_bus/data_bus/wr_bus/rd_bus/data_mask_bus/fc_bus) after the bus arbitrator has granted it to CPU or DMA.
Decodes its own address window, inserts programmable wait states, and performs byte-masked writes and full-word reads.
Signals completion by pulsing fc_bus for one cycle.
Drives data_bus and fc_bus only while responding; they are high-Z at all other times.

Parameters:
BASE_ADDR, 32'h0001_0000, byte base address of the window; must be aligned to the window size
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words (4 KiB default)
WAIT_CYCLES, 1, extra cycles between request capture and fc pulse (0..15)

Ports:
clk  input  1  clock
rst  input  1  reset
addr_bus  input  32  byte address from current master
data_bus  inout  32  write data in; read data driven by target during ACK
wr_bus  input  1  write request (level, held until fc)
rd_bus  input  1  read request (level, held until fc)
data_mask_bus  input  4  byte enables; bit i = byte i (data_bus[8i+7:8i])
fc_bus  output  1  function complete; tri-state
wp  input  1  write protect (present only with BUS_RAM_TARGET_WP_EN)

Behaviour:
- Reset rst: asynchronous, active-high; clock clk. On reset: state=IDLE, wait counter=0, data_bus=z, fc_bus=z, latched read data=0. RAM contents are not cleared.
- Select condition: sel = addr_bus[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. Word index = addr_bus[ADDR_W+1:2]. addr_bus[1:0] is ignored.
- Valid request: sel & (rd_bus ^ wr_bus). rd_bus & wr_bus together is a protocol error: no action, no fc, stay IDLE.
- FSM:
  - IDLE: on valid request, capture addr/rd/wr/mask/data. Go to WAIT if WAIT_CYCLES>0 (counter=WAIT_CYCLES-1), else go to ACK.
  - WAIT: counter decrements each cycle. At 0, go to ACK.
  - ACK: lasts exactly one cycle; then go to RELEASE.
  - RELEASE: stay until rd_bus=0 and wr_bus=0 (or sel=0), then go to IDLE. This prevents a held request from re-triggering.
- Write: on the edge entering ACK, update RAM[idx] byte i from the captured data iff captured mask[i]=1. Mask 4'b0000 still completes, with no change.
- Read: on the edge entering ACK, latch RAM[idx] (full 32 bits, mask ignored). data_bus is driven with the latched value during ACK only.
- Latency: request sampled at edge k → fc_bus=1 during cycle k+1+WAIT_CYCLES (WAIT_CYCLES=0 → next cycle).
- fc_bus drive: 0 in WAIT, 1 in ACK, z in IDLE and RELEASE.
- Request withdrawn during WAIT (rd and wr both 0): abort to IDLE, no write, fc not pulsed.
- Address change during WAIT is ignored; the captured address is used.
- Back-to-back access: minimum 1 IDLE cycle between transactions. The master must deassert rd/wr for at least one cycle after fc.
- rst mid-transaction: immediate return to IDLE, outputs z. A write not yet committed at ACK is lost.

Optional Feature:
BUS_RAM_TARGET_WP_EN: adds input wp.
- With the macro defined: when wp=1 at ACK entry, a write leaves the RAM unchanged but still completes normally with the fc pulse. Reads are unaffected.
- Without the macro: port wp is absent and all writes commit.

Test Plan:
- Reset, then idle bus (arbitrator zeros) → data_bus=z and fc_bus=z continuously, state IDLE.
- WAIT_CYCLES=1: write 32'hDEADBEEF to 32'h0001_0010, mask 4'hF → fc=1 exactly 2 cycles after request edge. Then read 32'h0001_0010 → data_bus=32'hDEADBEEF during the fc cycle, z the next cycle.
- Masked write 32'h1122_3344, mask 4'b0101 over 32'hDEADBEEF → read returns 32'hDE22_BE44.
- Out-of-window access 32'h0002_0000 with rd=1 held 10 cycles → fc_bus and data_bus stay z, RAM untouched.
- rd held high for 5 cycles after fc → exactly one fc pulse. rd=wr=1 → no fc. Withdraw wr during WAIT (WAIT_CYCLES=3) → no fc, RAM unchanged.
- Assert rst during WAIT of a write to word 4 → fc never pulses, word 4 keeps its old value. With BUS_RAM_TARGET_WP_EN defined and wp=1, a write of 32'h0 → fc pulses, RAM unchanged.
